pwm_wave_gen: RTL
=================

# pwm_wave_gen

Programmable square/PWM waveform source for the duty-cycle measurement subsystem. Produces `wave` with a period and high time set in clock cycles. Configuration is double-buffered and applied only at period boundaries, so the output never shows a truncated or glitched period. It drives the measurement front end on the board and serves as the stimulus source for on-chip self-test of the meter.

## Interface

Parameters:
- `CNT_W`, 16: width of the period and high-time counters and config inputs.
- `PERIOD_DEF`, 250: reset period in clk cycles (200 kHz at a 50 MHz clk).
- `HIGH_DEF`, 50: reset high time in clk cycles (20 % duty).

Ports:
- `clk`  in  1  system clock, 50 MHz; all logic on its rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `en`  in  1  run request; level-sensitive.
- `load`  in  1  one-cycle strobe that captures `period_in`/`high_in` into the pending registers.
- `period_in`  in  CNT_W  requested period in cycles.
- `high_in`  in  CNT_W  requested high time in cycles.
- `wave`  out  1  generated waveform; registered.
- `period_start`  out  1  one-cycle pulse in the first cycle of every generated period.
- `active`  out  1  high while the FSM is not IDLE.
- `cfg_err`  out  1  high after a rejected load; cleared by the next accepted load.

## Operation

- Registers:
  - Pending: `pend_period`, `pend_high`, `pend_valid`.
  - Active: `period_r`, `high_r`.
  - Counter: `cnt` (CNT_W bits), counting 0..`period_r`-1.
- Load validation:
  - A load is accepted when `period_in` ≥ 2 and `high_in` ≤ `period_in`.
  - A rejected load leaves the pending registers untouched and sets `cfg_err`.
  - An accepted load clears `cfg_err` and sets `pend_valid`.
  - A second accepted load before the next boundary overwrites the first; last writer wins.
- Apply point:
  - The pending values are copied into the active registers when the next period starts, either from IDLE or at a wrap.
  - `pend_valid` clears in that same cycle.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: `wave`=0, `cnt`=0. If `en`=1, move to HIGH, or straight to LOW when the applied `high_r`=0. Assert `period_start`.
  - HIGH: `wave`=1. When `cnt`=`high_r`-1, go to LOW. If `high_r`=`period_r`, stay in HIGH for the whole period.
  - LOW: `wave`=0. When `cnt`=`period_r`-1, the period ends.
  - End of period with `en`=1: restart in HIGH (or LOW when `high_r`=0), reset `cnt` to 0, pulse `period_start`.
  - End of period with `en`=0: go to IDLE.
- `en` falling mid-period does not cut the period short; the period always completes.
- Arithmetic:
  - Comparisons are unsigned at CNT_W width.
  - `cnt` never exceeds `period_r`-1, so no wrap-around beyond the period.
- Duty 0 % (`high_r`=0): `wave` stays 0 and `period_start` still pulses every period.
- Duty 100 % (`high_r`=`period_r`): `wave` stays 1 continuously across periods, with no low cycle.

## Timing

- Reset values:
  - `wave`=0, `period_start`=0, `active`=0, `cfg_err`=0, FSM IDLE.
  - `period_r`=PERIOD_DEF, `high_r`=HIGH_DEF, `pend_valid`=0.
- Start latency: `en` sampled high in IDLE at edge N gives `wave`=1 and `period_start`=1 in the cycle after edge N. `active` rises in the same cycle.
- Per period: `wave` is high for exactly `high_r` cycles and low for `period_r`-`high_r` cycles.
- `cfg_err` is updated at the edge after the `load` strobe.
- Load and apply in the same cycle: the values in the pending registers before that edge are the ones applied. A load arriving on the boundary edge is applied at the following period.
- `rst` asserted mid-period: all outputs take their reset values immediately, and the pending configuration is discarded.

## Configuration

- `PWM_GEN_BURST_EN`: adds input `burst_in` (8 bits, captured on accepted `load`) and output `burst_done`.
  - Defined, `burst_in`=N>0: after N complete periods the FSM goes to IDLE. `burst_done` pulses for one cycle at that transition.
  - Restarting needs `en` to go low and then high again.
  - Defined, N=0: continuous operation.
  - Undefined: ports absent; operation is always continuous.

## Test plan

- Reset then `en`=1 with defaults -> `wave` high for 50 cycles, low for 200, repeating at 5000 ns; `period_start` pulses every 250 cycles.
- Load 100/25 mid-period -> current 250/50 period completes unchanged; the next period is 25 high / 75 low.
- Load `period_in`=10, `high_in`=11 -> `cfg_err`=1 and the waveform is unchanged. Then load 10/5 -> `cfg_err`=0 and the next period is 5/5.
- Loads of 8/0 and 8/8 -> `wave` constant 0 and constant 1 respectively, with `period_start` every 8 cycles.
- `en` dropped 3 cycles into a period, and separately `rst` pulsed mid-HIGH:
  - `en` case: the period finishes, then `active`=0.
  - `rst` case: `wave`=0 at once; the next start uses 250/50.
- With `PWM_GEN_BURST_EN`, `burst_in`=3 -> exactly 3 periods, one `burst_done` pulse, then `wave`=0 while `en` stays 1.

Source files
------------

// File: rtl/pwm_wave_gen.sv
// pwm_wave_gen: PWM/square-wave source. Configuration is double-buffered and applied only at a period start.
// Optional feature macro PWM_GEN_BURST_EN adds burst_in/burst_done to run a fixed number of periods.
module pwm_wave_gen #(
    parameter int CNT_W      = 16,
    parameter int PERIOD_DEF = 250,
    parameter int HIGH_DEF   = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] high_in,
`ifdef PWM_GEN_BURST_EN
    input  logic [7:0]       burst_in,
    output logic             burst_done,
`endif
    output logic             wave,
    output logic             period_start,
    output logic             active,
    output logic             cfg_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    // A usable config needs at least two cycles per period and a high time that fits.
    function automatic logic cfg_ok(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] h);
        return (p >= CNT_W'(2)) && (h <= p);
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [1:0]       start_state_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] high_r;
    logic [CNT_W-1:0] pend_period;
    logic [CNT_W-1:0] pend_high;
    logic             pend_valid;
    logic [CNT_W-1:0] next_period_s;
    logic [CNT_W-1:0] next_high_s;
    logic             load_ok_s;
    logic             last_cyc_s;
    logic             high_end_s;
    logic             end_s;
    logic             apply_s;
    logic             start_s;
    logic             run_ok_s;
    logic             burst_last_s;

    assign load_ok_s     = load && cfg_ok(period_in, high_in);
    assign next_period_s = pend_valid ? pend_period : period_r;
    assign next_high_s   = pend_valid ? pend_high : high_r;
    assign start_state_s = (next_high_s == CNT_W'(0)) ? ST_LOW : ST_HIGH;
    assign last_cyc_s    = (cnt == (period_r - CNT_W'(1)));
    assign high_end_s    = (cnt == (high_r - CNT_W'(1)));
    assign end_s         = ((state_r == ST_HIGH) || (state_r == ST_LOW)) && last_cyc_s;

`ifdef PWM_GEN_BURST_EN
    logic [7:0] pend_burst_r;
    logic [7:0] burst_len_r;
    logic [7:0] burst_cnt_r;
    logic       hold_r;
    logic       burst_done_s;
    logic [7:0] next_burst_s;

    assign next_burst_s = pend_valid ? pend_burst_r : burst_len_r;
    // The last period of a burst is the one whose completion reaches the programmed count.
    assign burst_last_s = (burst_len_r != 8'd0) &&
                          (({1'b0, burst_cnt_r} + 9'd1) >= {1'b0, burst_len_r});
    assign burst_done_s = end_s && burst_last_s;
    assign run_ok_s     = ~hold_r;

    // Burst bookkeeping: applied length, completed-period count and the re-arm hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_burst_r <= 8'd0;
            burst_len_r  <= 8'd0;
            burst_cnt_r  <= 8'd0;
            hold_r       <= 1'b0;
            burst_done   <= 1'b0;
        end else begin
            burst_done <= burst_done_s;
            if (load_ok_s) begin
                pend_burst_r <= burst_in;
            end
            if (apply_s) begin
                burst_len_r <= next_burst_s;
            end
            if (apply_s && (state_r == ST_IDLE)) begin
                burst_cnt_r <= 8'd0;
            end else if (apply_s) begin
                burst_cnt_r <= burst_cnt_r + 8'd1;
            end
            if (burst_done_s) begin
                hold_r <= 1'b1;
            end else if (!en) begin
                hold_r <= 1'b0;
            end
        end
    end
`else
    assign run_ok_s     = 1'b1;
    assign burst_last_s = 1'b0;
`endif

    // Next-state logic: start/restart decisions and the in-period counter.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt;
        apply_s = 1'b0;
        start_s = 1'b0;
        if (end_s) begin
            cnt_s = CNT_W'(0);
            if (en && !burst_last_s) begin
                state_s = start_state_s;
                apply_s = 1'b1;
                start_s = 1'b1;
            end else begin
                state_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_s = CNT_W'(0);
                    if (en && run_ok_s) begin
                        state_s = start_state_s;
                        apply_s = 1'b1;
                        start_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_HIGH: begin
                    cnt_s = cnt + CNT_W'(1);
                    if (high_end_s) begin
                        state_s = ST_LOW;
                    end else begin
                        state_s = ST_HIGH;
                    end
                end
                ST_LOW: begin
                    cnt_s   = cnt + CNT_W'(1);
                    state_s = ST_LOW;
                end
                default: begin
                    cnt_s   = CNT_W'(0);
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM, counter, active configuration and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt          <= CNT_W'(0);
            period_r     <= CNT_W'(PERIOD_DEF);
            high_r       <= CNT_W'(HIGH_DEF);
            wave         <= 1'b0;
            period_start <= 1'b0;
            active       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt          <= cnt_s;
            wave         <= (state_s == ST_HIGH);
            period_start <= start_s;
            active       <= (state_s != ST_IDLE);
            if (apply_s) begin
                period_r <= next_period_s;
                high_r   <= next_high_s;
            end
        end
    end

    // Pending registers: a same-cycle load re-arms pend_valid after the old values are applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_period <= CNT_W'(0);
            pend_high   <= CNT_W'(0);
            pend_valid  <= 1'b0;
            cfg_err     <= 1'b0;
        end else if (load_ok_s) begin
            pend_period <= period_in;
            pend_high   <= high_in;
            pend_valid  <= 1'b1;
            cfg_err     <= 1'b0;
        end else begin
            if (load) begin
                cfg_err <= 1'b1;
            end
            if (apply_s) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule
